// File: rtl/cpu32_mem_pkg.sv
// cpu32_mem_pkg: shared constants for the cpu32 memory system.
//   MMIO_PAGE      - upper address half that selects the MMIO page
//   OFF_*          - MMIO register offsets within the page
//   STAT_*         - bit positions inside the CON_STAT read value
//   is_mmio()      - page decode helper shared by every address port
package cpu32_mem_pkg;

  localparam logic [15:0] MMIO_PAGE    = 16'hFFFF;

  localparam logic [15:0] OFF_CON_TX   = 16'h0000;
  localparam logic [15:0] OFF_CON_STAT = 16'h0004;
  localparam logic [15:0] OFF_CYCLE    = 16'h0008;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;

  function automatic logic is_mmio(input logic [31:0] addr);
    return addr[31:16] == MMIO_PAGE;
  endfunction

endpackage

// File: rtl/cpu32_con_fifo.sv
// cpu32_con_fifo: synchronous 8-bit FIFO for the console TX stream.
//   clk, reset  - clock, synchronous active-high reset (empties the FIFO)
//   push        - write push_data; dropped when full unless a pop happens too
//   pop         - remove the head entry; ignored when empty
//   head_data   - head entry, 0 when empty
//   full, empty - occupancy flags
// DEPTH must be a power of two >= 2 so the pointers wrap for free.
module cpu32_con_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head_data,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);

  // No bypass: a byte pushed into an empty FIFO appears on the next cycle.
  assign head_data = empty ? 8'h00 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage arrays are deliberately not reset; occupancy is tracked by
  // the pointers/count, and a reset on the array would block RAM inference.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cpu32_memsys.sv
// cpu32_memsys: memory-side responder for the cpu32 split I/D SRAM bus.
//   clk, reset          - clock, synchronous active-high reset
//   i_addr -> i_data    - instruction fetch, combinational RAM read
//   d_addr, d_data_w,
//   d_data_we -> d_data_r - data port, 1-cycle read latency, read-first
//   con_data/valid/ready - console TX byte stream out of the MMIO FIFO
//   ld_valid/addr/data,
//   ld_ready            - program loader, writes RAM only while reset is high
// MMIO page 0xFFFF_xxxx: CON_TX (0x0), CON_STAT (0x4), CYCLE (0x8).
// Build option: define CPU32_MEMSYS_CYCLE_CTR_EN to include the CYCLE counter;
// without it offset 0x8 reads 0 like any unmapped offset.
module cpu32_memsys
  import cpu32_mem_pkg::*;
#(
  parameter int ADDR_BITS  = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_addr,
  output logic [31:0] i_data,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_data_w,
  input  logic        d_data_we,
  output logic [31:0] d_data_r,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        ld_ready
);

  localparam int WORDS = 1 << ADDR_BITS;

  logic [31:0]          ram [WORDS];
  logic [ADDR_BITS-1:0] i_idx, d_idx, ld_idx, wr_idx;
  logic [31:0]          wr_data;
  logic                 ram_we;
  logic                 d_mmio;
  logic [31:0]          mmio_rdata;
  logic                 tx_push, stat_wr, con_pop;
  logic                 con_full, con_empty;
  logic                 overflow;

  // Address bits outside the word index alias; fold them here so they read as used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr, d_addr, ld_addr};

  assign i_idx  = i_addr[ADDR_BITS+1:2];
  assign d_idx  = d_addr[ADDR_BITS+1:2];
  assign ld_idx = ld_addr[ADDR_BITS+1:2];
  assign d_mmio = is_mmio(d_addr);

  assign i_data   = is_mmio(i_addr) ? 32'h0 : ram[i_idx];
  assign ld_ready = reset;

  // During reset only the loader owns the write port; afterwards only the core.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    ram_we  = 1'b0;
    wr_idx  = d_idx;
    wr_data = d_data_w;
    if (reset) begin
      ram_we  = ld_valid && !is_mmio(ld_addr);
      wr_idx  = ld_idx;
      wr_data = ld_data;
    end else begin
      ram_we  = d_data_we && !d_mmio;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[wr_idx] <= wr_data;
  end

`ifdef CPU32_MEMSYS_CYCLE_CTR_EN
  logic [31:0] cycle_ctr;
  always_ff @(posedge clk) begin
    if (reset) cycle_ctr <= '0;
    else       cycle_ctr <= cycle_ctr + 32'd1;
  end
`endif

  always_comb begin
    mmio_rdata = '0;
    case (d_addr[15:0])
      OFF_CON_STAT: begin
        mmio_rdata[STAT_EMPTY] = con_empty;
        mmio_rdata[STAT_FULL]  = con_full;
        mmio_rdata[STAT_OVF]   = overflow;
      end
`ifdef CPU32_MEMSYS_CYCLE_CTR_EN
      OFF_CYCLE: mmio_rdata = cycle_ctr;
`endif
      default: mmio_rdata = '0;
    endcase
  end

  // Read-first: the RAM word is sampled at the same edge that may overwrite it.
  always_ff @(posedge clk) begin
    if (reset) d_data_r <= '0;
    else       d_data_r <= d_mmio ? mmio_rdata : ram[d_idx];
  end

  assign tx_push = !reset && d_data_we && d_mmio && (d_addr[15:0] == OFF_CON_TX);
  assign stat_wr = !reset && d_data_we && d_mmio && (d_addr[15:0] == OFF_CON_STAT);
  assign con_pop = con_valid && con_ready;

  // Sticky drop flag; a simultaneous pop makes room, so that case is not a drop.
  always_ff @(posedge clk) begin
    if (reset)                                   overflow <= 1'b0;
    else if (stat_wr)                            overflow <= 1'b0;
    else if (tx_push && con_full && !con_pop)    overflow <= 1'b1;
  end

  cpu32_con_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_con_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (d_data_w[7:0]),
    .pop       (con_pop),
    .head_data (con_data),
    .full      (con_full),
    .empty     (con_empty)
  );

  assign con_valid = !con_empty;

endmodule

// File: tb/tb_cpu32_memsys.sv
// tb_cpu32_memsys: directed self-checking bench for cpu32_memsys.
// Inputs are driven and outputs sampled 1 ns after the rising edge.
module tb_cpu32_memsys;

  localparam logic [31:0] A_CON_TX   = 32'hFFFF_0000;
  localparam logic [31:0] A_CON_STAT = 32'hFFFF_0004;
  localparam logic [31:0] A_CYCLE    = 32'hFFFF_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_addr, i_data;
  logic [31:0] d_addr, d_data_w, d_data_r;
  logic        d_data_we;
  logic [7:0]  con_data;
  logic        con_valid, con_ready;
  logic        ld_valid, ld_ready;
  logic [31:0] ld_addr, ld_data;

  int n_checks = 0;
  int n_bad    = 0;

  cpu32_memsys dut (
    .clk       (clk),
    .reset     (reset),
    .i_addr    (i_addr),
    .i_data    (i_data),
    .d_addr    (d_addr),
    .d_data_w  (d_data_w),
    .d_data_we (d_data_we),
    .d_data_r  (d_data_r),
    .con_data  (con_data),
    .con_valid (con_valid),
    .con_ready (con_ready),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    d_addr    = addr;
    d_data_w  = data;
    d_data_we = 1'b1;
    tick();
    d_data_we = 1'b0;
  endtask

  task automatic load(input logic [31:0] addr, output logic [31:0] data);
    d_addr = addr;
    tick();
    data = d_data_r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, rd_a, rd_b;
    logic [7:0]  exp_q [8];

    reset = 1'b1; i_addr = '0; d_addr = '0; d_data_w = '0; d_data_we = 1'b0;
    con_ready = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    tick(); tick();

    check("rst_ld_ready", {31'b0, ld_ready}, 32'd1);
    check("rst_d_data_r", d_data_r, 32'h0);
    check("rst_con_valid", {31'b0, con_valid}, 32'd0);
    check("rst_con_data", {24'b0, con_data}, 32'h0);

    // Loader writes while reset is held; an MMIO loader address is discarded.
    ld_valid = 1'b1;
    ld_addr = 32'h100;      ld_data = 32'hDEAD_BEEF; tick();
    ld_addr = 32'h104;      ld_data = 32'h1234_5678; tick();
    ld_addr = 32'h300;      ld_data = 32'h1111_1111; tick();
    ld_addr = A_CON_TX;     ld_data = 32'h77;        tick();
    ld_valid = 1'b0;
    // Core store during reset must not reach RAM.
    store(32'h300, 32'h0000_0BAD);
    check("ld_mmio_no_push", {31'b0, con_valid}, 32'd0);

    reset = 1'b0;
    i_addr = 32'h104;
    #1;
    check("ld_ready_low", {31'b0, ld_ready}, 32'd0);
    check("post_rst_d_data_r", d_data_r, 32'h0);
    check("i_fetch_104", i_data, 32'h1234_5678);
    i_addr = 32'h0000_4107; #1;
    check("i_fetch_alias", i_data, 32'h1234_5678);
    i_addr = 32'hFFFF_0104; #1;
    check("i_fetch_mmio", i_data, 32'h0);

    load(32'h100, rd); check("d_load_100", rd, 32'hDEAD_BEEF);
    load(32'h300, rd); check("d_store_in_reset_ignored", rd, 32'h1111_1111);

    // Read-first on same-word read/write.
    store(32'h200, 32'h1);
    store(32'h200, 32'h2);
    check("read_first_old", d_data_r, 32'h1);
    load(32'h200, rd); check("read_after_write", rd, 32'h2);

    // Unmapped MMIO write must not alias into RAM.
    store(32'hFFFF_0100, 32'h0);
    load(32'h100, rd); check("mmio_wr_no_ram", rd, 32'hDEAD_BEEF);
    load(32'hFFFF_000C, rd); check("mmio_unmapped_rd", rd, 32'h0);

    // Console basic stream.
    con_ready = 1'b0;
    d_addr = A_CON_TX; d_data_w = 32'h41; d_data_we = 1'b1; #1;
    check("con_no_bypass", {31'b0, con_valid}, 32'd0);
    tick();
    check("con_valid_next", {31'b0, con_valid}, 32'd1);
    check("con_head_A", {24'b0, con_data}, 32'h41);
    d_data_w = 32'h42; tick();
    d_data_we = 1'b0; tick();
    check("con_hold_A", {24'b0, con_data}, 32'h41);
    load(A_CON_TX, rd); check("con_tx_rd_zero", rd, 32'h0);
    con_ready = 1'b1; #1;
    check("con_pop_A", {24'b0, con_data}, 32'h41);
    tick();
    check("con_pop_B", {24'b0, con_data}, 32'h42);
    tick();
    check("con_drained", {31'b0, con_valid}, 32'd0);
    check("con_empty_data", {24'b0, con_data}, 32'h0);
    con_ready = 1'b0;

    // Overflow: nine pushes into a depth-8 FIFO.
    for (int i = 1; i <= 9; i++) store(A_CON_TX, 32'(i));
    load(A_CON_STAT, rd); check("stat_ovf_full", rd, 32'h6);
    store(A_CON_STAT, 32'h0);
    load(A_CON_STAT, rd); check("stat_ovf_cleared", rd, 32'h2);

    // Full FIFO with push and pop together: no drop, no overflow.
    con_ready = 1'b1;
    store(A_CON_TX, 32'h99);
    con_ready = 1'b0;
    load(A_CON_STAT, rd); check("stat_full_push_pop", rd, 32'h2);

    exp_q = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h99};
    con_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain_%0d", k), {24'b0, con_data}, {24'b0, exp_q[k]});
      tick();
    end
    check("drain_empty", {31'b0, con_valid}, 32'd0);
    con_ready = 1'b0;
    load(A_CON_STAT, rd); check("stat_empty", rd, 32'h1);

`ifdef CPU32_MEMSYS_CYCLE_CTR_EN
    load(A_CYCLE, rd_a);
    repeat (10) tick();
    rd_b = d_data_r;
    check("cycle_delta", rd_b - rd_a, 32'd10);
    force dut.cycle_ctr = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_ctr;
    tick(); check("cycle_max", d_data_r, 32'hFFFF_FFFF);
    tick(); check("cycle_wrap", d_data_r, 32'h0);
`else
    load(A_CYCLE, rd_a);
    rd_b = rd_a;
    check("cycle_absent", rd_b, 32'h0);
`endif

    // Reset mid-stream flushes the FIFO but keeps RAM.
    for (int i = 0; i < 3; i++) store(A_CON_TX, 32'h60 + 32'(i));
    check("queued_valid", {31'b0, con_valid}, 32'd1);
    reset = 1'b1; tick(); reset = 1'b0; #1;
    check("flush_valid", {31'b0, con_valid}, 32'd0);
    check("flush_data", {24'b0, con_data}, 32'h0);
    check("flush_d_data_r", d_data_r, 32'h0);
    load(A_CON_STAT, rd); check("flush_stat", rd, 32'h1);
    load(32'h104, rd); check("ram_kept", rd, 32'h1234_5678);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu32_memsys.md
Name: cpu32_memsys

Overview:
Memory-side responder for the cpu32 core's split instruction/data SRAM interface. It serves instruction fetch as a combinational read and the data port as a synchronous SRAM with 1-cycle read latency. It also decodes a small MMIO page holding a console TX FIFO with a valid/ready output stream and a cycle counter. A program loader port writes RAM while the system is held in reset.

Parameters:
ADDR_BITS, 12, word-address width; RAM holds 2^ADDR_BITS 32-bit words (16 KB at default).
FIFO_DEPTH, 8, console FIFO entries; power of two, 2 or more.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
i_addr  in  32  instruction byte address
i_data  out  32  instruction word, combinational
d_addr  in  32  data byte address
d_data_w  in  32  store data
d_data_we  in  1  store strobe
d_data_r  out  32  load data, registered
con_data  out  8  console byte at FIFO head
con_valid  out  1  FIFO non-empty
con_ready  in  1  sink accepts byte
ld_valid  in  1  loader write request
ld_addr  in  32  loader byte address
ld_data  in  32  loader word
ld_ready  out  1  loader accepted; equals reset

Behaviour:
- Reset values are driven while reset is high and on the first cycle after it deasserts:
  - d_data_r = 0, con_valid = 0, con_data = 0.
  - FIFO count = 0, overflow flag = 0, cycle counter = 0.
  - RAM contents are not reset.
- Address decode:
  - MMIO when addr[31:16] == 16'hFFFF; otherwise RAM.
  - RAM word index = addr[ADDR_BITS+1:2]; addr[1:0] are ignored; upper bits alias.
- I-port: i_data = RAM[index(i_addr)] combinationally, including during reset. An MMIO i_addr returns 0.
- D-port reads:
  - d_data_r at edge N+1 = value addressed by d_addr at edge N. It updates every cycle; there is no read enable.
  - A RAM read in the same cycle as a write to the same word returns the old data (read-first).
- D-port writes:
  - d_data_we = 1 at the edge writes d_data_w to RAM, or acts on the MMIO register.
  - An MMIO write never modifies RAM.
- MMIO map (offset = addr[15:0]):
  - 0x0000 CON_TX:
    - Write pushes d_data_w[7:0].
    - If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and overflow is set (sticky).
    - Reads return 0.
  - 0x0004 CON_STAT:
    - Read returns {29'b0, overflow, full, empty}.
    - A write with any data clears overflow.
  - 0x0008 CYCLE: read returns the free-running 32-bit counter. It increments every non-reset cycle and wraps 0xFFFFFFFF -> 0. Writes are ignored.
  - Other offsets read 0; writes to them are ignored.
  - MMIO read values are sampled at the same edge as the address (1-cycle latency, same as RAM).
- Console stream:
  - con_valid = !empty; con_data = head byte, or 0 when empty.
  - Pop on con_valid & con_ready at the edge. con_data is held stable while con_valid & !con_ready.
  - Push and pop in the same cycle with the FIFO full: both occur, count unchanged, no overflow.
  - A push into an empty FIFO becomes visible on the next cycle (no bypass).
  - Pointers wrap modulo FIFO_DEPTH.
- Loader:
  - ld_ready = reset.
  - ld_valid & reset at the edge writes RAM[index(ld_addr)] = ld_data. An MMIO ld_addr is accepted and discarded.
  - D-port writes are ignored while reset is high.
  - Reset asserted mid-stream flushes the FIFO immediately; bytes not yet popped are lost.

Optional Feature:
CPU32_MEMSYS_CYCLE_CTR_EN
- Defined: the CYCLE counter is instantiated and readable at 0x0008.
- Undefined: no counter flops; offset 0x0008 reads 0, like any unmapped offset.

Decomposition:
- Package cpu32_mem_pkg holds:
  - MMIO_PAGE = 16'hFFFF.
  - Offsets OFF_CON_TX, OFF_CON_STAT, OFF_CYCLE.
  - STAT bit indices STAT_EMPTY = 0, STAT_FULL = 1, STAT_OVF = 2.
- Sub-module: cpu32_con_fifo, a synchronous FIFO with push/pop, full/empty, count, parameter DEPTH and 8-bit width.

Test Plan:
- Loader: reset = 1, ld writes 0x100 <- 0xDEADBEEF and 0x104 <- 0x12345678; release reset -> i_addr = 0x104 gives i_data = 0x12345678 same cycle; d_addr = 0x100 gives d_data_r = 0xDEADBEEF one cycle later.
- Read-first: mem[0x200] = 0x1; store 0x2 to 0x200 with d_addr = 0x200 -> next-cycle d_data_r = 0x1; a following read returns 0x2.
- Console: con_ready = 0; store 'A', 'B' to 0xFFFF0000 -> con_valid next cycle, con_data = 0x41 held; con_ready = 1 -> 0x41 then 0x42, then con_valid = 0.
- Overflow: con_ready = 0; push 9 bytes (DEPTH 8) -> CON_STAT read = 0x6 and the 9th byte is absent; write CON_STAT -> reads 0x2; full + push + pop in the same cycle -> no overflow.
- Cycle counter (macro on): read 0xFFFF0008 at cycles K and K+10 -> difference 10; force the counter to 0xFFFFFFFF -> wraps to 0. Macro off -> read 0.
- Reset mid-stream: 3 bytes queued, reset pulsed for 1 cycle -> con_valid = 0 and CON_STAT = 0x1 after reset; RAM data preserved.
